// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between a byte-wide CPU
// port and a block-addressed (32-bit) data memory with busywait handshakes.
module dcache_controller #(
  parameter int INDEX_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int NBLK  = 1 << INDEX_W;
  localparam int TAG_W = 6 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t             state_q;
  logic [31:0]        data_q  [NBLK];
  logic [TAG_W-1:0]   tag_q   [NBLK];
  logic [NBLK-1:0]    valid_q;
  logic [NBLK-1:0]    dirty_q;
  logic               mem_read_q;
  logic               mem_write_q;

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_idx;
  logic [1:0]         addr_off;
  logic               req;
  logic               hit;

  assign addr_tag = address[7:2+INDEX_W];
  assign addr_idx = address[1+INDEX_W:2];
  assign addr_off = address[1:0];

  // Both strobes together is an illegal request and is ignored entirely.
  assign req = read ^ write;
  assign hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  assign busywait      = req && !((state_q == IDLE) && hit);
  assign readdata      = data_q[addr_idx][{addr_off, 3'b000} +: 8];
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_writedata = data_q[addr_idx];
  // Write-back targets the evicted block; fetch targets the requested one.
  assign mem_address   = (state_q == WRITEBACK) ? {tag_q[addr_idx], addr_idx}
                                                : {addr_tag, addr_idx};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (write) begin
                data_q[addr_idx][{addr_off, 3'b000} +: 8] <= writedata;
                dirty_q[addr_idx] <= 1'b1;
              end
            end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state_q     <= FETCH;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state_q    <= UPDATE;
            mem_read_q <= 1'b0;
          end
        end
        UPDATE: begin
          data_q[addr_idx]  <= mem_readdata;
          tag_q[addr_idx]   <= addr_tag;
          valid_q[addr_idx] <= 1'b1;
          dirty_q[addr_idx] <= 1'b0;
          state_q           <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a memory stub that holds
// mem_busywait high for the first 4 cycles of every strobe.
module tb_dcache_controller;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int n_cmp;
  int n_bad;
  int overlap;
  int stub_cnt;

  int          rd_cycles;
  int          wr_cycles;
  logic [5:0]  rd_addr;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  dcache_controller #(.INDEX_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory stub: busy for 4 cycles after a strobe rises, fixed per-block data.
  assign mem_busywait = (mem_read || mem_write) && (stub_cnt < 4);
  always_comb begin
    case (mem_address)
      6'h05:   mem_readdata = 32'hDDCCBBAA;
      6'h2D:   mem_readdata = 32'h87654321;
      default: mem_readdata = {4{2'b10, mem_address}};
    endcase
  end
  always @(posedge clock) begin
    if (!(mem_read || mem_write) || !mem_busywait) stub_cnt <= 0;
    else stub_cnt <= stub_cnt + 1;
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply a request and wait until busywait clears; returns busy cycle count.
  task automatic txn(input logic r, input logic w, input logic [7:0] a,
                     input logic [7:0] d, output int bw);
    bit done;
    read      = r;
    write     = w;
    address   = a;
    writedata = d;
    bw        = 0;
    done      = 1'b0;
    rd_cycles = 0;
    wr_cycles = 0;
    rd_addr   = '0;
    wr_addr   = '0;
    wr_data   = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (mem_read) begin
        rd_cycles++;
        rd_addr = mem_address;
      end
      if (mem_write) begin
        wr_cycles++;
        wr_addr = mem_address;
        wr_data = mem_writedata;
      end
      if (!busywait) begin
        done = 1'b1;
        break;
      end
      bw++;
    end
    if (!done) chk("timeout", 32'd1, 32'd0);
  endtask

  // Let the completing edge happen (commits write hits), then drop the request.
  task automatic release_req();
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  int bw;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    overlap   = 0;
    stub_cnt  = 0;
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = '0;
    writedata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    @(posedge clock);
    #1;

    // Cold miss on 0x14: fetch block 0x05
    txn(1'b1, 1'b0, 8'h14, 8'h00, bw);
    chk("miss_bw_cycles", 32'(bw), 32'd7);
    chk("miss_rd_addr", 32'(rd_addr), 32'h05);
    chk("miss_rd_cycles", 32'(rd_cycles), 32'd5);
    chk("miss_no_wr", 32'(wr_cycles), 32'd0);
    chk("miss_readdata", 32'(readdata), 32'hAA);
    release_req();

    txn(1'b1, 1'b0, 8'h17, 8'h00, bw);
    chk("hit_bw", 32'(bw), 32'd0);
    chk("hit_readdata", 32'(readdata), 32'hDD);
    chk("hit_no_strobe", 32'(rd_cycles + wr_cycles), 32'd0);
    release_req();

    txn(1'b0, 1'b1, 8'h15, 8'h11, bw);
    chk("whit_bw", 32'(bw), 32'd0);
    chk("whit_no_strobe", 32'(rd_cycles + wr_cycles), 32'd0);
    release_req();
    txn(1'b1, 1'b0, 8'h15, 8'h00, bw);
    chk("whit_readback", 32'(readdata), 32'h11);
    release_req();

    // Conflict on index 5 with a dirty resident line: write-back then fetch
    txn(1'b1, 1'b0, 8'hB4, 8'h00, bw);
    chk("dirty_bw_cycles", 32'(bw), 32'd12);
    chk("dirty_wr_addr", 32'(wr_addr), 32'h05);
    chk("dirty_wr_data", wr_data, 32'hDDCC11AA);
    chk("dirty_wr_cycles", 32'(wr_cycles), 32'd5);
    chk("dirty_rd_addr", 32'(rd_addr), 32'h2D);
    chk("dirty_rd_cycles", 32'(rd_cycles), 32'd5);
    chk("dirty_readdata", 32'(readdata), 32'h21);
    release_req();

    // read and write together: ignored, array left alone
    txn(1'b1, 1'b1, 8'hB5, 8'h99, bw);
    chk("both_bw", 32'(bw), 32'd0);
    chk("both_no_strobe", 32'(rd_cycles + wr_cycles), 32'd0);
    release_req();
    txn(1'b1, 1'b0, 8'hB5, 8'h00, bw);
    chk("both_bw_after", 32'(bw), 32'd0);
    chk("both_unchanged", 32'(readdata), 32'h43);
    release_req();

    // Write miss on a clean/invalid index: allocate, then write hit
    txn(1'b0, 1'b1, 8'h1A, 8'h5A, bw);
    chk("wmiss_bw_cycles", 32'(bw), 32'd7);
    chk("wmiss_rd_addr", 32'(rd_addr), 32'h06);
    chk("wmiss_no_wr", 32'(wr_cycles), 32'd0);
    release_req();
    txn(1'b1, 1'b0, 8'h1A, 8'h00, bw);
    chk("wmiss_byte2", 32'(readdata), 32'h5A);
    release_req();
    txn(1'b1, 1'b0, 8'h1B, 8'h00, bw);
    chk("wmiss_byte3", 32'(readdata), 32'h86);
    release_req();

    // Reset in the middle of a fetch
    read    = 1'b1;
    address = 8'h08;
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_mem_read", 32'(mem_read), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    read  = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_busywait", 32'(busywait), 32'd0);
    @(posedge clock);
    #1;
    // 0xB4 was valid and clean before reset; now it must miss as a clean miss
    txn(1'b1, 1'b0, 8'hB4, 8'h00, bw);
    chk("postrst_bw_cycles", 32'(bw), 32'd7);
    chk("postrst_no_wr", 32'(wr_cycles), 32'd0);
    chk("postrst_readdata", 32'(readdata), 32'h21);
    release_req();
    txn(1'b1, 1'b0, 8'h14, 8'h00, bw);
    chk("postrst_evict_bw", 32'(bw), 32'd7);
    chk("postrst_evict_data", 32'(readdata), 32'hAA);
    release_req();

    @(negedge clock);
    chk("no_strobe_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
